// File: rtl/cq_viola_led_pkg.sv
// Shared definitions for the cq_viola_led LED output port: register map
// word addresses and status bit positions.
package cq_viola_led_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/cq_viola_led_blinker.sv
// Blink prescaler for cq_viola_led. Counts 0..period and toggles phase on
// each terminal count, giving a half-period of period+1 clocks. A zero
// period parks the counter and forces phase low. restart (a period write)
// clears both on the same edge and takes priority over a terminal count.
module cq_viola_led_blinker #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;

  // Prescaler counter and phase toggle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart || (period == '0)) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == period) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/cq_viola_led.sv
// cq_viola_led: Avalon-MM LED output port with per-bit hardware blink.
// Holds the data register, blink mask and blink period; the blinker
// sub-module produces the shared blink phase. readdata has one cycle of
// latency and is refreshed every clock from address.
// Optional feature macro: CQ_VIOLA_LED_BITOP_EN enables the outset (4) and
// outclear (5) write-only registers; without it those addresses are
// reserved.
module cq_viola_led
  import cq_viola_led_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PERIOD_W    = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic                wr_en;
  logic                period_wr;
  logic [WIDTH-1:0]    wr_bits;
  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    blink_mask;
  logic [PERIOD_W-1:0] period;
  logic                phase;
  logic [31:0]         readdata_nxt;
  logic                unused_writedata;

  assign wr_en            = chipselect && !write_n;
  assign period_wr        = wr_en && (address == ADDR_PERIOD);
  assign wr_bits          = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  // Output data register, including optional set/clear bit operations
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:   data <= wr_bits;
`ifdef CQ_VIOLA_LED_BITOP_EN
        ADDR_OUTSET: data <= data | wr_bits;
        ADDR_OUTCLR: data <= data & ~wr_bits;
`endif
        default:     data <= data;
      endcase
    end
  end

  // Blink configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask <= '0;
      period     <= '0;
    end else begin
      if (wr_en && (address == ADDR_MASK)) blink_mask <= wr_bits;
      if (period_wr)                       period     <= writedata[PERIOD_W-1:0];
    end
  end

  cq_viola_led_blinker #(
    .PERIOD_W (PERIOD_W)
  ) u_blinker (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period),
    .restart (period_wr),
    .phase   (phase)
  );

  // Read mux: zero-extended register selected by address
  always_comb begin
    readdata_nxt = '0;
    case (address)
      ADDR_DATA:   readdata_nxt[WIDTH-1:0]        = data;
      ADDR_MASK:   readdata_nxt[WIDTH-1:0]        = blink_mask;
      ADDR_PERIOD: readdata_nxt[PERIOD_W-1:0]     = period;
      ADDR_STATUS: readdata_nxt[STATUS_PHASE_BIT] = phase;
      default:     readdata_nxt                   = '0;
    endcase
  end

  // Registered read data and LED drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      readdata <= readdata_nxt;
      out_port <= data ^ (blink_mask & {WIDTH{phase}});
    end
  end

endmodule

// File: tb/tb_cq_viola_led.sv
// Directed self-checking bench for cq_viola_led (WIDTH=10, RESET_VALUE=0x2A).
module tb_cq_viola_led;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cq_viola_led #(
    .WIDTH       (10),
    .RESET_VALUE (10'h2A),
    .PERIOD_W    (24)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    address = a;
    @(posedge clk); #1;
    v = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;
    repeat (3) @(posedge clk);
    #3;
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata_held got=%h exp=%h", readdata, 32'h0); end
    reset_n = 1'b1;
    #1;
    total++;
    if (out_port !== 10'h2A) begin bad++; $display("FAIL rst_out_port got=%h exp=%h", out_port, 10'h2A); end
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata got=%h exp=%h", readdata, 32'h0); end
    bus_read(3'd0, v);
    total++;
    if (v !== 32'h2A) begin bad++; $display("FAIL rst_read_data got=%h exp=%h", v, 32'h2A); end
  endtask

  task automatic test_data_write;
    logic [31:0] v;
    bus_write(3'd0, 32'h0000_03FF);
    total++;
    if (out_port !== 10'h2A) begin bad++; $display("FAIL dw_out_same_edge got=%h exp=%h", out_port, 10'h2A); end
    @(posedge clk); #1;
    total++;
    if (out_port !== 10'h3FF) begin bad++; $display("FAIL dw_out_next_edge got=%h exp=%h", out_port, 10'h3FF); end
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd0, v);
    total++;
    if (v !== 32'h3FF) begin bad++; $display("FAIL dw_read_data got=%h exp=%h", v, 32'h3FF); end
    bus_read(3'd1, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL dw_read_mask got=%h exp=%h", v, 32'h0); end
    bus_read(3'd2, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL dw_read_period got=%h exp=%h", v, 32'h0); end
    bus_read(3'd3, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL dw_read_status got=%h exp=%h", v, 32'h0); end
    bus_read(3'd7, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL dw_read_rsvd got=%h exp=%h", v, 32'h0); end
    total++;
    if (out_port !== 10'h3FF) begin bad++; $display("FAIL dw_out_after_ro got=%h exp=%h", out_port, 10'h3FF); end
  endtask

  // Leaves the blink running with phase=1 (17 clocks after the period write)
  task automatic test_blink;
    logic [31:0] v;
    logic [9:0]  exp_out;
    int          ph;
    bus_write(3'd0, 32'h001);
    bus_write(3'd1, 32'h003);
    bus_read(3'd1, v);
    total++;
    if (v !== 32'h3) begin bad++; $display("FAIL bl_read_mask got=%h exp=%h", v, 32'h3); end
    bus_write(3'd2, 32'd4);
    address = 3'd3;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      ph      = ((k - 1) / 5) % 2;
      exp_out = (ph != 0) ? 10'h002 : 10'h001;
      total++;
      if (out_port !== exp_out) begin bad++; $display("FAIL bl_out k=%0d got=%h exp=%h", k, out_port, exp_out); end
      total++;
      if (readdata !== 32'(ph)) begin bad++; $display("FAIL bl_status k=%0d got=%h exp=%h", k, readdata, 32'(ph)); end
    end
  endtask

  task automatic test_restart;
    logic [9:0] exp_out;
    int         ph;
    bus_write(3'd2, 32'd2);
    total++;
    if (out_port !== 10'h002) begin bad++; $display("FAIL rs_out_at_write got=%h exp=%h", out_port, 10'h002); end
    address = 3'd3;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      ph      = ((k - 1) / 3) % 2;
      exp_out = (ph != 0) ? 10'h002 : 10'h001;
      total++;
      if (out_port !== exp_out) begin bad++; $display("FAIL rs_out k=%0d got=%h exp=%h", k, out_port, exp_out); end
      total++;
      if (readdata !== 32'(ph)) begin bad++; $display("FAIL rs_status k=%0d got=%h exp=%h", k, readdata, 32'(ph)); end
    end
  endtask

  task automatic test_stop;
    logic [31:0] v;
    bus_write(3'd2, 32'd0);
    address = 3'd3;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      total++;
      if (out_port !== 10'h001) begin bad++; $display("FAIL st_out k=%0d got=%h exp=%h", k, out_port, 10'h001); end
      total++;
      if (readdata !== 32'h0) begin bad++; $display("FAIL st_status k=%0d got=%h exp=%h", k, readdata, 32'h0); end
    end
    bus_read(3'd2, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL st_read_period got=%h exp=%h", v, 32'h0); end
  endtask

  task automatic test_bitop;
    logic [31:0] v;
    logic [31:0] exp_set;
    logic [31:0] exp_clr;
`ifdef CQ_VIOLA_LED_BITOP_EN
    exp_set = 32'h0F3;
    exp_clr = 32'h0C3;
`else
    exp_set = 32'h0F0;
    exp_clr = 32'h0F0;
`endif
    bus_write(3'd1, 32'h0);
    bus_write(3'd0, 32'h0F0);
    bus_write(3'd4, 32'h003);
    bus_read(3'd0, v);
    total++;
    if (v !== exp_set) begin bad++; $display("FAIL bo_set_data got=%h exp=%h", v, exp_set); end
    total++;
    if (out_port !== exp_set[9:0]) begin bad++; $display("FAIL bo_set_out got=%h exp=%h", out_port, exp_set[9:0]); end
    bus_write(3'd5, 32'h030);
    bus_read(3'd0, v);
    total++;
    if (v !== exp_clr) begin bad++; $display("FAIL bo_clr_data got=%h exp=%h", v, exp_clr); end
    total++;
    if (out_port !== exp_clr[9:0]) begin bad++; $display("FAIL bo_clr_out got=%h exp=%h", out_port, exp_clr[9:0]); end
    bus_read(3'd4, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL bo_read_outset got=%h exp=%h", v, 32'h0); end
    bus_read(3'd5, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL bo_read_outclr got=%h exp=%h", v, 32'h0); end
  endtask

  task automatic test_async_reset;
    bus_write(3'd0, 32'h001);
    bus_write(3'd1, 32'h003);
    bus_write(3'd2, 32'd1);
    address = 3'd3;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (out_port !== 10'h002) begin bad++; $display("FAIL ar_pre_out got=%h exp=%h", out_port, 10'h002); end
    #3 reset_n = 1'b0;
    #1;
    total++;
    if (out_port !== 10'h2A) begin bad++; $display("FAIL ar_out got=%h exp=%h", out_port, 10'h2A); end
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL ar_readdata got=%h exp=%h", readdata, 32'h0); end
    total++;
    if (dut.u_blinker.phase !== 1'b0) begin bad++; $display("FAIL ar_phase got=%b exp=%b", dut.u_blinker.phase, 1'b0); end
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    bus_write(3'd1, 32'h003);
    address = 3'd3;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      total++;
      if (out_port !== 10'h2A) begin bad++; $display("FAIL ar_idle_out k=%0d got=%h exp=%h", k, out_port, 10'h2A); end
      total++;
      if (readdata !== 32'h0) begin bad++; $display("FAIL ar_idle_status k=%0d got=%h exp=%h", k, readdata, 32'h0); end
    end
    bus_write(3'd2, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (out_port !== 10'h029) begin bad++; $display("FAIL ar_resume_out got=%h exp=%h", out_port, 10'h029); end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_blink();
    test_restart();
    test_stop();
    test_bitop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
